// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues instruction memory requests and
// buffers returning instructions in a small FIFO for decode.
//
// Ports:
//   clk, reset                   clock, async active-low reset
//   imem_req_valid/ready/addr    word-addressed fetch request
//   imem_resp_valid/inst         in-order instruction returns
//   inst_valid/ready/data/pc     buffer head presented to decode
//   redirect_valid/pc            flush and restart fetch at redirect_pc
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam ptr_t LAST = ptr_t'(DEPTH - 1);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_q, drop_d;
  cnt_t        count_q, count_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc_d   [DEPTH];

  logic [CW:0] used;
  logic        credit;
  logic        req_fire;
  logic        pop;
  logic        push;
  logic        dropping;
  cnt_t        resp_dec;

  function automatic ptr_t nxt(input ptr_t p);
    return (p == LAST) ? '0 : p + ptr_t'(1);
  endfunction

  // Outstanding requests plus buffered entries never exceed DEPTH, so
  // every response is guaranteed a free slot.
  assign used     = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit   = used < CAP;

  // reset gating keeps the request low while reset is held, even
  // though the cleared counters would otherwise grant credit.
  assign imem_req_valid = reset && credit && !redirect_valid;
  assign imem_req_addr  = imem_req_valid ? fetch_pc_q : '0;

  assign inst_valid = (count_q != '0) && !redirect_valid;
  assign inst_data  = inst_valid ? data_q[head_q] : '0;
  assign inst_pc    = inst_valid ? pc_q[head_q]   : '0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign dropping = drop_q != '0;
  assign push     = imem_resp_valid && !dropping && !redirect_valid;
  assign resp_dec = cnt_t'(imem_resp_valid);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    data_d     = data_q;
    pc_d       = pc_q;

    if (redirect_valid) begin
      // Everything still outstanding is stale, including a
      // response landing in this very cycle.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      inflight_d = inflight_q - resp_dec;
      drop_d     = inflight_q - resp_dec;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd1;
      end
      inflight_d = inflight_q + cnt_t'(req_fire) - resp_dec;
      if (imem_resp_valid && dropping) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (push) begin
        data_d[tail_q] = imem_resp_inst;
        pc_d[tail_q]   = resp_pc_q;
        tail_d         = nxt(tail_q);
        resp_pc_d      = resp_pc_q + 32'd1;
      end
      if (pop) begin
        head_d = nxt(head_q);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

  a_resp_has_request: assert property (
    @(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (inflight_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with an in-order latency memory model
// and a scoreboard of expected {pc, inst} pairs checked at decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int          n_chk;
  int          n_pass;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  int          acc_cnt;
  int          lat;
  int          mq_due[$];
  logic [31:0] mq_addr[$];

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Memory: one response per cycle, in order, lat cycles after accept.
  task automatic mem_proc();
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      #2;
      if (!reset) begin
        mq_due.delete();
        mq_addr.delete();
        imem_resp_valid = 1'b0;
      end else begin
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_inst  = mq_addr[0] + 32'h100;
          void'(mq_due.pop_front());
          void'(mq_addr.pop_front());
        end else begin
          imem_resp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_addr);
          exp_addr = exp_addr + 32'd1;
          acc_cnt++;
          mq_due.push_back(cyc + lat);
          mq_addr.push_back(imem_req_addr);
        end
      end
    end
  endtask

  task automatic mon_proc();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_inst: pc %h data %h, none expected",
                   inst_pc, inst_data);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e[63:32]);
          chk("inst_data", inst_data, e[31:0]);
        end
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      p = pc + 32'(i);
      exp_q.push_back({p, p + 32'h100});
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_addr       = pc;
    exp_q.delete();
  endtask

  // Returns at a falling edge once every expected entry was seen.
  task automatic wait_drain();
    int i;
    for (i = 0; i < 80; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (i == 80) chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_inst = '0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    lat = 1;
    exp_addr = '0;
    acc_cnt = 0;
    fork
      mem_proc();
      mon_proc();
    join_none

    // Reset state, then stream with L=1.
    repeat (3) @(negedge clk);
    #4 chk_reset_outs("rst");
    @(negedge clk);
    reset = 1'b1;
    inst_ready = 1'b1;
    push_exp(32'h0, 8);
    #4;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'd0);
    chk("fill_c0", 32'(inst_valid), 32'd0);
    @(negedge clk);
    #4 chk("fill_c1", 32'(inst_valid), 32'd0);
    @(negedge clk);
    #4 chk("fill_c2", 32'(inst_valid), 32'd1);
    wait_drain();
    inst_ready = 1'b0;

    // Backpressure: exactly DEPTH requests, head held at pc 0.
    repeat (10) @(negedge clk);
    do_redirect(32'h0);
    acc_cnt = 0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    chk("bp_requests", 32'(acc_cnt), 32'd4);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_head_valid", 32'(inst_valid), 32'd1);
    chk("bp_head_pc", inst_pc, 32'h0);
    chk("bp_head_data", inst_data, 32'h100);
    @(negedge clk);
    push_exp(32'h0, 4);
    inst_ready = 1'b1;
    wait_drain();
    inst_ready = 1'b0;

    // Redirect with two requests in flight at L=3.
    repeat (10) @(negedge clk);
    lat = 3;
    do_redirect(32'h20);
    acc_cnt = 0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_redirect(32'h40);
    push_exp(32'h40, 4);
    inst_ready = 1'b1;
    #4;
    chk("inflight_pre", 32'(acc_cnt), 32'd2);
    chk("redir_inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_drain();
    inst_ready = 1'b0;

    // Redirect coincident with a response and a would-be pop.
    repeat (12) @(negedge clk);
    lat = 1;
    do_redirect(32'h80);
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    chk("pre_coinc_valid", 32'(inst_valid), 32'd1);
    chk("pre_coinc_pc", inst_pc, 32'h80);
    @(negedge clk);
    do_redirect(32'h90);
    push_exp(32'h90, 3);
    inst_ready = 1'b1;
    #4;
    chk("coinc_resp", 32'(imem_resp_valid), 32'd1);
    chk("coinc_gate", 32'(inst_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #4 chk("coinc_flushed", 32'(inst_valid), 32'd0);
    wait_drain();
    inst_ready = 1'b0;

    // PC wrap-around.
    repeat (10) @(negedge clk);
    do_redirect(32'hFFFF_FFFE);
    push_exp(32'hFFFF_FFFE, 4);
    inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_drain();
    inst_ready = 1'b0;

    // Async reset mid-stream with three entries buffered.
    repeat (10) @(negedge clk);
    do_redirect(32'h200);
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    chk("pre_rst_pc", inst_pc, 32'h200);
    #1 reset = 1'b0;
    #3 chk_reset_outs("async_rst");
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_addr = 32'h0;
    exp_q.delete();
    push_exp(32'h0, 3);
    inst_ready = 1'b1;
    #4;
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_req_addr", imem_req_addr, 32'h0);
    wait_drain();
    inst_ready = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the core's decode/execute logic. It owns the fetch PC and issues word-addressed requests to instruction memory under a valid/ready handshake, and it buffers returning instructions in a small FIFO. It presents each buffered instruction with its PC to decode, again under valid/ready. A redirect input (branch/jump/trap target) flushes the buffer and discards in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `DEPTH`, default 4: instruction buffer entries. This is also the cap on in-flight requests plus buffered entries. Legal range is 2..16.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. It is asserted when low, asynchronously clears all state, and is released synchronously to `clk`.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word address (PC) of the request.
- `imem_resp_valid`  in  1  memory returns one instruction. Responses arrive in request order, at least 1 cycle after acceptance.
- `imem_resp_inst`  in  32  returned instruction word.
- `inst_valid`  out  1  buffer head valid for decode.
- `inst_ready`  in  1  decode consumes the head this cycle.
- `inst_data`  out  32  head instruction.
- `inst_pc`  out  32  PC of head instruction.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC.

## Operation
- PC is a word address. Each accepted request advances `fetch_pc` by 1, modulo 2^32: 32'hFFFF_FFFF wraps to 0.
- Registered state:
  - `fetch_pc`
  - `resp_pc`: PC tagged onto the next kept response.
  - `inflight` (0..DEPTH)
  - `drop_cnt` (0..DEPTH)
  - FIFO storage with `count` (0..DEPTH) and wrapping head/tail pointers.
- Request credit: `imem_req_valid = (inflight + count < DEPTH) && !redirect_valid`. It depends only on registered state and `redirect_valid`, so no overflow is possible.
- `imem_req_addr = fetch_pc` whenever `imem_req_valid` is high.
- Response handling:
  - If `drop_cnt != 0`, the response is discarded and `drop_cnt` decrements.
  - Otherwise `{resp_pc, imem_resp_inst}` is pushed and `resp_pc` increments.
  - Every response decrements `inflight`.
  - A response while `inflight == 0` is a protocol violation and must fire a simulation assertion.
- Output: `inst_valid = (count != 0) && !redirect_valid`. `inst_data` and `inst_pc` come from the head. A pop occurs on `inst_valid && inst_ready`.
- Simultaneous push and pop with `count == DEPTH` cannot occur, because of the credit rule. Push and pop together leave `count` unchanged.
- Redirect has priority over every other update in that cycle:
  - `fetch_pc` and `resp_pc` are set to `redirect_pc`.
  - FIFO is emptied (`count` = 0, pointers = 0).
  - `drop_cnt` is set to `inflight - imem_resp_valid`.
  - `inflight` is set to `inflight - imem_resp_valid`.
  - No request is issued and no pop occurs.
  - A response arriving in the redirect cycle is discarded.
- A redirect while `drop_cnt != 0` overwrites `drop_cnt` with the formula above. This is correct because all outstanding responses are stale.
- Reset values:
  - `fetch_pc` and `resp_pc` = RESET_PC.
  - `inflight`, `drop_cnt`, and `count` = 0.
  - `imem_req_valid` = 0 while reset is asserted; it rises in the first cycle after release.
  - `inst_valid` = 0.
  - `imem_req_addr`, `inst_data`, and `inst_pc` = 0.
- Reset asserted mid-operation discards all state. Responses still arriving after release are not tracked, and the environment must not deliver them.

## Timing
- Request accepted at cycle N with response at N+L gives `inst_valid` at N+L+1. The buffer is registered and has no bypass.
- With L=1, DEPTH=4, and `inst_ready` held high, throughput is 1 instruction/cycle after a 2-cycle fill.
- Redirect at cycle R:
  - New PC is requested at R+1 if credit allows.
  - `inst_valid` is low in cycle R and remains low until the first kept response is buffered.
- `inst_ready` low holds head data stable. Requests continue until `inflight + count == DEPTH`.
- No combinational path from `inst_ready` or `imem_req_ready` to any output. Only `redirect_valid` gates `imem_req_valid` and `inst_valid` combinationally.

## Test plan
- **Reset and stream:** release reset with a memory of L=1 returning `inst = addr + 32'h100`, `inst_ready` = 1.
  - `imem_req_addr` must go 0, 1, 2, …
  - Decode must see `inst_pc` 0, 1, 2 with `inst_data` 0x100, 0x101, 0x102, the first valid 2 cycles after the first request.
- **Backpressure:** `inst_ready` = 0 for 10 cycles.
  - Requests stop after exactly 4 outstanding-or-buffered.
  - Head stays at pc 0.
  - Release yields pcs 0..3 in order with no loss or duplication.
- **Redirect with in-flight:** L=3, redirect to 0x40 while `inflight` = 2.
  - Two stale responses are dropped.
  - Next `inst_pc` seen is 0x40, followed by 0x41.
- **Redirect coincident with response and pop:** redirect in a cycle where `imem_resp_valid` = 1 and `count` = 2.
  - That response is dropped and the FIFO is empty next cycle.
  - The first delivered pc equals `redirect_pc`.
- **Wrap-around:** redirect to 32'hFFFF_FFFE.
  - Delivered pcs are FFFF_FFFE, FFFF_FFFF, 0000_0000.
- **Async reset mid-stream:** assert `reset` low mid-cycle with `count` = 3.
  - All outputs drop immediately to their reset values.
  - After release, fetch restarts at RESET_PC.
